// File: rtl/seg_scan_capture.sv
// Seven-segment bus monitor: waits for a stable frame on one anode, then decodes it back to BCD per digit.
// Optional macro SEG_SCAN_BLANK_DETECT_EN: when defined, the all-off pattern is a legal blank digit.
module seg_scan_capture #(
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned NDIG          = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [0:6]          seg,
   input  logic [NDIG-1:0]     an,
   output logic [4*NDIG-1:0]   bcd,
   output logic [NDIG-1:0]     valid,
   output logic [NDIG-1:0]     err,
   output logic                upd,
   output logic [1:0]          upd_idx
);

   localparam int unsigned SEGW  = 7;
   localparam int unsigned SMPW  = NDIG + SEGW;
   localparam int unsigned CNTW  = 8;
   localparam int unsigned BCDW  = 4 * NDIG;
   localparam logic [CNTW-1:0] CNT_MAX    = '1;
   localparam logic [CNTW-1:0] CNT_TARGET = CNTW'(STABLE_CYCLES);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      TRACK   = 2'd1,
      CAPTURE = 2'd2,
      HOLD    = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [SMPW-1:0]    s_q;
   logic [CNTW-1:0]    cnt_q;
   logic [BCDW-1:0]    bcd_d;
   logic [NDIG-1:0]    valid_d, err_d;
   logic               upd_d;
   logic [1:0]         upd_idx_d;

   logic [SMPW-1:0]    smp;
   logic               same;
   logic [1:0]         cap_idx;
   logic [5:0]         dec;

   // Exactly one active-low anode selects a digit
   function automatic logic is_onehot(input logic [3:0] a);
      case (a)
         4'b1110, 4'b1101, 4'b1011, 4'b0111: return 1'b1;
         default:                            return 1'b0;
      endcase
   endfunction

   function automatic logic [1:0] anode_idx(input logic [3:0] a);
      case (a)
         4'b1101: return 2'd1;
         4'b1011: return 2'd2;
         4'b0111: return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

   // Returns {legal, blank, digit}; pattern bits are a..g left to right, 0 = lit
   function automatic logic [5:0] decode(input logic [6:0] p);
      case (p)
         7'b0000001: return {2'b10, 4'd0};
         7'b1001111: return {2'b10, 4'd1};
         7'b0010010: return {2'b10, 4'd2};
         7'b0000110: return {2'b10, 4'd3};
         7'b1001100: return {2'b10, 4'd4};
         7'b0100100: return {2'b10, 4'd5};
         7'b0100000: return {2'b10, 4'd6};
         7'b0001111: return {2'b10, 4'd7};
         7'b0000000: return {2'b10, 4'd8};
         7'b0000100: return {2'b10, 4'd9};
`ifdef SEG_SCAN_BLANK_DETECT_EN
         7'b1111111: return {2'b01, 4'd0};
`endif
         default:    return 6'b000000;
      endcase
   endfunction

   assign smp     = {an, seg};
   assign same    = (smp == s_q);
   assign cap_idx = anode_idx(s_q[SMPW-1:SEGW]);
   assign dec     = decode(s_q[SEGW-1:0]);

   // Sample register and stability counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s_q   <= {4'hF, 7'h7F};
         cnt_q <= '0;
      end else begin
         s_q <= smp;
         if (!same)                 cnt_q <= CNTW'(1);
         else if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNTW'(1);
      end
   end

   // State and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         bcd     <= '0;
         valid   <= '0;
         err     <= '0;
         upd     <= 1'b0;
         upd_idx <= 2'd0;
      end else begin
         state_q <= state_d;
         bcd     <= bcd_d;
         valid   <= valid_d;
         err     <= err_d;
         upd     <= upd_d;
         upd_idx <= upd_idx_d;
      end
   end

   // Next state; a capture updates only the selected digit's fields
   always_comb begin
      state_d   = state_q;
      bcd_d     = bcd;
      valid_d   = valid;
      err_d     = err;
      upd_d     = 1'b0;
      upd_idx_d = upd_idx;
      case (state_q)
         IDLE: begin
            if (is_onehot(smp[SMPW-1:SEGW])) state_d = TRACK;
         end
         TRACK: begin
            if (!same) begin
               state_d = is_onehot(smp[SMPW-1:SEGW]) ? TRACK : IDLE;
            end else if (cnt_q == CNT_TARGET) begin
               state_d   = CAPTURE;
               upd_d     = 1'b1;
               upd_idx_d = cap_idx;
               if (dec[5]) bcd_d[{cap_idx, 2'b00} +: 4] = dec[3:0];
               valid_d[cap_idx] = dec[5];
               err_d[cap_idx]   = ~dec[5] & ~dec[4];
            end
         end
         CAPTURE, HOLD: begin
            // A change right after capture must not be swallowed by HOLD
            if (!same) state_d = is_onehot(smp[SMPW-1:SEGW]) ? TRACK : IDLE;
            else       state_d = HOLD;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture: capture latency, scan, glitch, illegal, no-digit, reset and blank cases.
module tb_seg_scan_capture;

   logic        clk;
   logic        reset;
   logic [0:6]  seg;
   logic [3:0]  an;
   logic [15:0] bcd;
   logic [3:0]  valid;
   logic [3:0]  err;
   logic        upd;
   logic [1:0]  upd_idx;

   int checks;
   int errors;
   int upd_cnt;

   seg_scan_capture #(.STABLE_CYCLES(4), .NDIG(4)) dut (
      .clk     (clk),
      .reset   (reset),
      .seg     (seg),
      .an      (an),
      .bcd     (bcd),
      .valid   (valid),
      .err     (err),
      .upd     (upd),
      .upd_idx (upd_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse counter: value held during a cycle is seen at the following edge
   always @(posedge clk) if (upd === 1'b1) upd_cnt <= upd_cnt + 1;

   task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
      @(negedge clk);
      an  = a;
      seg = s;
      repeat (n) @(posedge clk);
   endtask

   task automatic test_reset;
      reset = 1'b1;
      an    = 4'hF;
      seg   = 7'h7F;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (bcd !== 16'h0 || valid !== 4'h0 || err !== 4'h0 || upd !== 1'b0 || upd_idx !== 2'd0) begin
         errors++;
         $display("FAIL reset: bcd=%h valid=%b err=%b upd=%b idx=%0d, want all zero", bcd, valid, err, upd, upd_idx);
      end
      reset = 1'b0;
      upd_cnt = 0;
   endtask

   task automatic test_single_capture;
      @(negedge clk);
      an  = 4'b1110;
      seg = 7'b0010010;
      repeat (4) @(posedge clk);
      @(negedge clk);
      checks++;
      if (upd !== 1'b0 || bcd !== 16'h0) begin
         errors++;
         $display("FAIL early_capture: upd=%b bcd=%h, want upd=0 bcd=0000", upd, bcd);
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (upd !== 1'b1 || upd_idx !== 2'd0 || bcd !== 16'h0002 || valid !== 4'b0001 || err !== 4'b0000) begin
         errors++;
         $display("FAIL capture_2: upd=%b idx=%0d bcd=%h valid=%b err=%b, want 1 0 0002 0001 0000",
                  upd, upd_idx, bcd, valid, err);
      end
      repeat (5) @(posedge clk);
      @(negedge clk);
      checks++;
      if (upd_cnt !== 1) begin
         errors++;
         $display("FAIL single_pulse: pulses=%0d, want 1", upd_cnt);
      end
   endtask

   task automatic test_scan;
      upd_cnt = 0;
      hold(4'b0111, 7'b0000100, 6);
      hold(4'b1011, 7'b1001100, 6);
      hold(4'b1101, 7'b0001111, 6);
      hold(4'b1110, 7'b1001111, 6);
      @(negedge clk);
      checks++;
      if (bcd !== 16'h9471 || valid !== 4'b1111 || err !== 4'b0000) begin
         errors++;
         $display("FAIL scan: bcd=%h valid=%b err=%b, want 9471 1111 0000", bcd, valid, err);
      end
      checks++;
      if (upd_cnt !== 4 || upd_idx !== 2'd0) begin
         errors++;
         $display("FAIL scan_pulses: pulses=%0d idx=%0d, want 4 0", upd_cnt, upd_idx);
      end
   endtask

   task automatic test_glitch;
      upd_cnt = 0;
      hold(4'b1101, 7'b0000110, 3);
      hold(4'b1111, 7'b0000110, 10);
      @(negedge clk);
      checks++;
      if (bcd !== 16'h9471 || upd_cnt !== 0) begin
         errors++;
         $display("FAIL glitch: bcd=%h pulses=%0d, want 9471 0", bcd, upd_cnt);
      end
   endtask

   task automatic test_anode_switch;
      upd_cnt = 0;
      hold(4'b1101, 7'b0000000, 3);
      hold(4'b1110, 7'b0000000, 3);
      hold(4'b1111, 7'b0000000, 6);
      @(negedge clk);
      checks++;
      if (bcd !== 16'h9471 || upd_cnt !== 0) begin
         errors++;
         $display("FAIL anode_switch: bcd=%h pulses=%0d, want 9471 0", bcd, upd_cnt);
      end
   endtask

   task automatic test_illegal;
      upd_cnt = 0;
      hold(4'b0111, 7'b0110000, 8);
      @(negedge clk);
      checks++;
      if (bcd !== 16'h9471 || valid !== 4'b0111 || err !== 4'b1000 || upd_cnt !== 1 || upd_idx !== 2'd3) begin
         errors++;
         $display("FAIL illegal: bcd=%h valid=%b err=%b pulses=%0d idx=%0d, want 9471 0111 1000 1 3",
                  bcd, valid, err, upd_cnt, upd_idx);
      end
      hold(4'b0111, 7'b1001111, 8);
      @(negedge clk);
      checks++;
      if (bcd !== 16'h1471 || valid !== 4'b1111 || err !== 4'b0000 || upd_cnt !== 2) begin
         errors++;
         $display("FAIL recover: bcd=%h valid=%b err=%b pulses=%0d, want 1471 1111 0000 2",
                  bcd, valid, err, upd_cnt);
      end
   endtask

   task automatic test_no_digit;
      upd_cnt = 0;
      hold(4'b1100, 7'b0000000, 20);
      hold(4'b1111, 7'b0000000, 20);
      @(negedge clk);
      checks++;
      if (upd_cnt !== 0 || bcd !== 16'h1471 || valid !== 4'b1111 || err !== 4'b0000) begin
         errors++;
         $display("FAIL no_digit: pulses=%0d bcd=%h valid=%b err=%b, want 0 1471 1111 0000",
                  upd_cnt, bcd, valid, err);
      end
   endtask

   task automatic test_blank;
      upd_cnt = 0;
      hold(4'b1011, 7'b1111111, 8);
      @(negedge clk);
      checks++;
`ifdef SEG_SCAN_BLANK_DETECT_EN
      if (bcd !== 16'h1471 || valid !== 4'b1011 || err !== 4'b0000 || upd_cnt !== 1 || upd_idx !== 2'd2) begin
         errors++;
         $display("FAIL blank: bcd=%h valid=%b err=%b pulses=%0d idx=%0d, want 1471 1011 0000 1 2",
                  bcd, valid, err, upd_cnt, upd_idx);
      end
`else
      if (bcd !== 16'h1471 || valid !== 4'b1011 || err !== 4'b0100 || upd_cnt !== 1 || upd_idx !== 2'd2) begin
         errors++;
         $display("FAIL blank: bcd=%h valid=%b err=%b pulses=%0d idx=%0d, want 1471 1011 0100 1 2",
                  bcd, valid, err, upd_cnt, upd_idx);
      end
`endif
   endtask

   task automatic test_mid_reset;
      @(negedge clk);
      an  = 4'b1110;
      seg = 7'b0000000;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks++;
      if (bcd !== 16'h0 || valid !== 4'h0 || err !== 4'h0 || upd !== 1'b0 || upd_idx !== 2'd0) begin
         errors++;
         $display("FAIL mid_reset: bcd=%h valid=%b err=%b upd=%b idx=%0d, want all zero",
                  bcd, valid, err, upd, upd_idx);
      end
      @(negedge clk);
      reset = 1'b0;
      upd_cnt = 0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      checks++;
      if (upd !== 1'b0 || upd_cnt !== 0 || bcd !== 16'h0) begin
         errors++;
         $display("FAIL reset_window: upd=%b pulses=%0d bcd=%h, want 0 0 0000", upd, upd_cnt, bcd);
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (upd !== 1'b1 || bcd !== 16'h0008 || valid !== 4'b0001 || err !== 4'b0000) begin
         errors++;
         $display("FAIL reset_capture: upd=%b bcd=%h valid=%b err=%b, want 1 0008 0001 0000",
                  upd, bcd, valid, err);
      end
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      upd_cnt = 0;
      test_reset;
      test_single_capture;
      test_scan;
      test_glitch;
      test_anode_switch;
      test_illegal;
      test_no_digit;
      test_blank;
      test_mid_reset;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
